// File: rtl/demux_sched_1x8.sv
// Round-robin scheduler for a 1x8 demux: one-entry buffer, IDLE/SEEK/SEND FSM.
// Optional SEND stall timeout with drop pulse: define DEMUX_SCHED_TIMEOUT_EN.
module demux_sched_1x8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       ch_en,
  input  logic [7:0]       ch_ready,
  output logic [2:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       out_valid,
  output logic             busy,
  output logic             drop
);

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    SEND
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       ptr;
  logic [2:0]       found;
  logic [2:0]       idx;
  logic             hit;
  logic             done;
  logic             expire;
  logic [WIDTH-1:0] buffer;

  // Scan downward so the smallest offset from ptr wins.
  always_comb begin
    hit   = 1'b0;
    found = ptr;
    idx   = ptr;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (ch_en[idx]) begin
        hit   = 1'b1;
        found = idx;
      end
    end
  end

  assign done = (state == SEND) && ch_ready[sel];

`ifdef DEMUX_SCHED_TIMEOUT_EN
  logic [3:0] stall;
  logic       drop_q;

  assign expire = (state == SEND) && !ch_ready[sel] && (stall == 4'hF);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall  <= 4'd0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= expire;
      if (state == SEEK)
        stall <= 4'd0;
      else if (state == SEND && !ch_ready[sel])
        stall <= stall + 4'd1;
    end
  end

  assign drop = drop_q;
`else
  assign expire = 1'b0;
  assign drop   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = SEEK;
      SEEK:    if (hit) state_nxt = SEND;
      SEND:    if (done || expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      sel      <= 3'd0;
      out_data <= '0;
      buffer   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid)
        buffer <= in_data;
      if (state == SEEK && hit) begin
        sel      <= found;
        out_data <= buffer;
      end
      if (done || expire)
        ptr <= sel + 3'd1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == SEND) ? (8'b1 << sel) : 8'h00;

endmodule

// File: tb/tb_demux_sched_1x8.sv
// Directed bench for demux_sched_1x8 with hand-computed expectations.
// Timeout scenario runs only when DEMUX_SCHED_TIMEOUT_EN is defined.
module tb_demux_sched_1x8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] ch_en;
  logic [7:0] ch_ready;
  logic [2:0] sel;
  logic [7:0] out_data;
  logic [7:0] out_valid;
  logic       busy;
  logic       drop;

  int vectors = 0;
  int miscompares = 0;

  demux_sched_1x8 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ch_en(ch_en), .ch_ready(ch_ready),
    .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    step();
    step();
    rst = 1'b0;
  endtask

  // Full transfer from IDLE with ch_ready high: capture, SEEK, SEND+complete.
  task automatic send_word(input logic [7:0] d, input logic [2:0] es);
    in_valid = 1'b1;
    in_data = d;
    step();
    in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 8'h00) begin
      miscompares++;
      $display("FAIL seek busy=%b in_ready=%b out_valid=%h want 1 0 00", busy, in_ready, out_valid);
    end
    step();
    vectors++;
    if (out_valid !== (8'h01 << es) || sel !== es || out_data !== d) begin
      miscompares++;
      $display("FAIL send sel=%0d out_valid=%h out_data=%h want %0d %h %h",
               sel, out_valid, out_data, es, 8'h01 << es, d);
    end
    step();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 8'h00 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done in_ready=%b out_valid=%h busy=%b want 1 00 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    ch_en = 8'hFF;
    ch_ready = 8'hFF;
    do_reset();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 8'h00 || sel !== 3'd0 ||
        busy !== 1'b0 || drop !== 1'b0 || out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset in_ready=%b out_valid=%h sel=%0d busy=%b drop=%b out_data=%h",
               in_ready, out_valid, sel, busy, drop, out_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    ch_en = 8'hFF;
    ch_ready = 8'hFF;
    send_word(8'hA1, 3'd0);
    send_word(8'hA2, 3'd1);
    send_word(8'hA3, 3'd2);
  endtask

  task automatic test_sparse_mask();
    do_reset();
    ch_en = 8'b1000_0100;
    ch_ready = 8'hFF;
    send_word(8'h11, 3'd2);
    send_word(8'h22, 3'd7);
    send_word(8'h33, 3'd2);
  endtask

  task automatic test_backpressure();
    do_reset();
    ch_en = 8'hFF;
    ch_ready = 8'hFE;
    in_valid = 1'b1;
    in_data = 8'h5C;
    step();
    in_valid = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (out_valid !== 8'h01 || out_data !== 8'h5C || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall%0d out_valid=%h out_data=%h in_ready=%b want 01 5c 0",
                 k, out_valid, out_data, in_ready);
      end
      step();
    end
    ch_ready = 8'hFF;
    step();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 8'h00) begin
      miscompares++;
      $display("FAIL bp_release in_ready=%b out_valid=%h want 1 00", in_ready, out_valid);
    end
    send_word(8'h5D, 3'd1);
  endtask

  task automatic test_empty_mask_reset();
    do_reset();
    ch_en = 8'h00;
    ch_ready = 8'hFF;
    in_valid = 1'b1;
    in_data = 8'h77;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if (busy !== 1'b1 || out_valid !== 8'h00 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL empty%0d busy=%b out_valid=%h in_ready=%b want 1 00 0",
                 k, busy, out_valid, in_ready);
      end
    end
    ch_en = 8'h10;
    ch_ready = 8'h00;
    step();
    vectors++;
    if (sel !== 3'd4 || out_valid !== 8'h10 || out_data !== 8'h77) begin
      miscompares++;
      $display("FAIL ch4 sel=%0d out_valid=%h out_data=%h want 4 10 77", sel, out_valid, out_data);
    end
    ch_ready = 8'h10;
    step();
    ch_en = 8'hFF;
    ch_ready = 8'h00;
    in_valid = 1'b1;
    in_data = 8'h99;
    step();
    in_valid = 1'b0;
    step();
    vectors++;
    if (sel !== 3'd5 || out_valid !== 8'h20) begin
      miscompares++;
      $display("FAIL pre_rst sel=%0d out_valid=%h want 5 20", sel, out_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (out_valid !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_rst out_valid=%h sel=%0d busy=%b in_ready=%b want 00 0 0 1",
               out_valid, sel, busy, in_ready);
    end
    ch_ready = 8'hFF;
    send_word(8'h42, 3'd0);
  endtask

`ifdef DEMUX_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    ch_en = 8'hFF;
    ch_ready = 8'h00;
    in_valid = 1'b1;
    in_data = 8'hE5;
    step();
    in_valid = 1'b0;
    step();
    for (int k = 1; k <= 16; k++) begin
      vectors++;
      if (drop !== 1'b0 || out_valid !== 8'h01) begin
        miscompares++;
        $display("FAIL to_wait%0d drop=%b out_valid=%h want 0 01", k, drop, out_valid);
      end
      if (k < 16) step();
    end
    step();
    vectors++;
    if (drop !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL to_drop drop=%b busy=%b in_ready=%b want 1 0 1", drop, busy, in_ready);
    end
    ch_ready = 8'hFF;
    step();
    vectors++;
    if (drop !== 1'b0) begin
      miscompares++;
      $display("FAIL to_pulse drop=%b want 0", drop);
    end
    send_word(8'hE6, 3'd1);
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    ch_en = 8'h00;
    ch_ready = 8'h00;
    test_reset();
    test_round_robin();
    test_sparse_mask();
    test_backpressure();
    test_empty_mask_reset();
`ifdef DEMUX_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux_sched_1x8.md
# demux_sched_1x8

Round-robin scheduler that sequences a 1-to-8 demultiplexer datapath. Accepts words from a single upstream source via a valid/ready handshake and drives the 3-bit select and one-hot per-channel valids. It delivers each word to the next enabled channel in rotating order, then holds it until that channel accepts it. It sits directly in front of the 1x8 demux tree and owns its `sel` input.

## Interface
- `WIDTH`, default 8: data word width in bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  upstream data word.
- `in_valid`  in  1  upstream word present.
- `in_ready`  out  1  block can capture a word this cycle.
- `ch_en`  in  8  per-channel enable mask; bit i enables channel i.
- `ch_ready`  in  8  per-channel sink ready.
- `sel`  out  3  demux select: the channel currently addressed.
- `out_data`  out  WIDTH  buffered word presented to the demux.
- `out_valid`  out  8  one-hot valid; bit `sel` set only in SEND.
- `busy`  out  1  high in SEEK or SEND.
- `drop`  out  1  one-cycle pulse when a word is discarded by timeout.

## Operation
- One-entry data buffer, 3-bit round-robin pointer `ptr`, and an FSM with three states: IDLE, SEEK, SEND.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`, capture `in_data` into the buffer and go to SEEK.
- **SEEK**
  - `in_ready` = 0.
  - Rotating priority search over `ch_en`, starting at `ptr` inclusive and going upward modulo 8.
  - On the first enabled channel c: register `sel` = c and go to SEND.
  - If `ch_en` == 0, stay in SEEK and hold the buffer. Re-evaluate every cycle.
- **SEND**
  - `out_valid` = 1 << `sel`, `out_data` = buffer.
  - A transfer completes on an edge where `ch_ready[sel]` = 1. At that edge: `ptr` = `sel` + 1 (3-bit wrap, so 7 → 0), go to IDLE.
  - Changes to `ch_en` during SEND are ignored; the word stays committed to `sel`.
- `ch_ready` bits other than `sel` have no effect in any state.
- `out_valid` = 0 in IDLE and SEEK. `out_data` and `sel` hold their last values outside SEND.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, `ptr` 0, `sel` 0, `out_data` 0, `out_valid` 0, `in_ready` 1, `busy` 0, `drop` 0.
- Latency:
  - Word captured at edge N.
  - SEEK during cycle N+1.
  - `out_valid` high from cycle N+2.
  - Earliest completion at edge N+2.
- Maximum throughput: one word per 3 cycles.
- `in_ready` is a registered state decode; it does not depend combinationally on `in_valid` or `ch_ready`.
- `rst` asserted in any state overrides everything at that edge:
  - The buffered word is lost and no transfer is counted.
  - All outputs return to reset values on the next cycle.
- `ch_ready[sel]` rising in the same cycle SEND is entered counts as a completion at the next edge.

## Configuration
- Macro `DEMUX_SCHED_TIMEOUT_EN`:
  - **Defined:** a 4-bit stall counter clears on SEND entry and increments each SEND cycle with `ch_ready[sel]` = 0. On the edge where the counter reaches 15 with `ch_ready[sel]` still 0:
    - The word is discarded.
    - `drop` pulses high for the following cycle.
    - `ptr` = `sel` + 1.
    - The FSM goes to IDLE.
  - A `ch_ready[sel]` = 1 on that same edge wins: normal completion, no drop.
  - **Not defined:** SEND waits indefinitely and `drop` is tied to 0.

## Test plan
- **Reset:** hold `rst` 2 cycles, then release. Required: `in_ready` = 1, `out_valid` = 0, `sel` = 0, `busy` = 0.
- **Round-robin:** `ch_en` = 8'hFF, all `ch_ready` = 1, send words 0xA1, 0xA2, 0xA3 back-to-back. Required: delivered on channels 0, 1, 2 with `out_valid` = 8'h01, 8'h02, 8'h04, at 3-cycle spacing.
- **Sparse mask:** `ch_en` = 8'b1000_0100, send 3 words from reset. Required: `sel` sequence 2, 7, 2, showing wrap past 7.
- **Backpressure:** hold `ch_ready[sel]` = 0 for 5 cycles in SEND. Required: `out_valid` and `out_data` stable, `in_ready` = 0, completion on the edge `ch_ready` rises.
- **Empty mask and mid-operation reset:**
  - `ch_en` = 0 after capture: FSM stays in SEEK with `busy` = 1.
  - Then set `ch_en` = 8'h10: delivery on channel 4.
  - Assert `rst` during a later SEND: `out_valid` = 0 next cycle and `ptr` = 0.
- **Timeout (with `DEMUX_SCHED_TIMEOUT_EN`):** `ch_ready` = 0 throughout SEND. Required: `drop` pulses once, 16 cycles after SEND entry; the next word goes to `sel` + 1.
